// File: rtl/sram_arb_pkg.sv
// Shared IDs, widths, defaults and request payload for the sram-like bus arbiter.
package sram_arb_pkg;

  localparam int unsigned ID_W             = 1;
  localparam int unsigned STARVE_W         = 4;
  localparam int unsigned DEF_OUTSTANDING  = 4;
  localparam int unsigned DEF_STARVE_LIMIT = 3;

  localparam logic [ID_W-1:0] ID_INST = 1'b0;
  localparam logic [ID_W-1:0] ID_DATA = 1'b1;

  // One master's slave-side request fields, muxed as a unit.
  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
  } sram_req_t;

endpackage

// File: rtl/sram_tag_fifo.sv
// In-order 1-bit master-ID FIFO recording which master owns each outstanding response.
module sram_tag_fifo
  import sram_arb_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_OUTSTANDING
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [ID_W-1:0]          push_id,
  input  logic                     pop,
  output logic [ID_W-1:0]          head_id,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ID_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head_id = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_id;
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Merges the inst-fetch and data sram-like ports onto one slave port with
// zero-latency handshakes, in-order response routing and bounded inst starvation.
module sram_like_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned OUTSTANDING  = DEF_OUTSTANDING,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,

  output logic        s_req,
  output logic        s_wr,
  output logic [1:0]  s_size,
  output logic [3:0]  s_wen,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata,
  input  logic        s_addr_ok,
  input  logic        s_data_ok,

  output logic        err_unexpected
);

  localparam int unsigned CNT_W = $clog2(OUTSTANDING) + 1;

  sram_req_t           inst_bus;
  sram_req_t           data_bus;
  sram_req_t           sel_bus;
  logic [ID_W-1:0]     sel_id;
  logic [ID_W-1:0]     lock_id;
  logic [ID_W-1:0]     head_id;
  logic                lock_valid;
  logic                sel_req;
  logic                accept;
  logic                pop_valid;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CNT_W-1:0]    fifo_count;
  logic [STARVE_W-1:0] starve_cnt;
  logic [STARVE_W-1:0] starve_nxt;
  logic                starve_hit;

  assign inst_bus = '{wr: inst_wr, size: inst_size, wen: 4'b0000,
                      addr: inst_addr, wdata: inst_wdata};
  assign data_bus = '{wr: data_wr, size: data_size, wen: data_wen,
                      addr: data_addr, wdata: data_wdata};

  assign starve_hit = (starve_cnt == STARVE_W'(STARVE_LIMIT));

  // Grant selection: a pending lock wins, otherwise data unless inst has starved.
  always_comb begin
    sel_id = ID_DATA;
    if (lock_valid) begin
      sel_id = lock_id;
    end else if (inst_req && (!data_req || starve_hit)) begin
      sel_id = ID_INST;
    end
  end

  assign sel_req = (sel_id == ID_INST) ? inst_req : data_req;
  assign sel_bus = (sel_id == ID_INST) ? inst_bus : data_bus;

  // resetn gate keeps the slave request quiet while reset is asserted.
  assign s_req   = resetn && sel_req && !fifo_full;
  assign s_wr    = sel_bus.wr;
  assign s_size  = sel_bus.size;
  assign s_wen   = sel_bus.wen;
  assign s_addr  = sel_bus.addr;
  assign s_wdata = sel_bus.wdata;

  assign accept       = s_req && s_addr_ok;
  assign inst_addr_ok = accept && (sel_id == ID_INST);
  assign data_addr_ok = accept && (sel_id == ID_DATA);

  assign pop_valid    = s_data_ok && !fifo_empty;
  assign inst_data_ok = pop_valid && (head_id == ID_INST);
  assign data_data_ok = pop_valid && (head_id == ID_DATA);
  assign inst_rdata   = s_rdata;
  assign data_rdata   = s_rdata;

  // Starvation counter: counts data wins against a waiting inst, saturating.
  always_comb begin
    starve_nxt = starve_cnt;
    if (!inst_req || (accept && (sel_id == ID_INST))) begin
      starve_nxt = '0;
    end else if (accept && !starve_hit) begin
      starve_nxt = starve_cnt + STARVE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_valid     <= 1'b0;
      lock_id        <= ID_INST;
      starve_cnt     <= '0;
      err_unexpected <= 1'b0;
    end else begin
      lock_valid <= s_req && !s_addr_ok;
      if (s_req && !s_addr_ok) lock_id <= sel_id;
      starve_cnt <= starve_nxt;
      if (s_data_ok && (fifo_count == '0)) err_unexpected <= 1'b1;
    end
  end

  sram_tag_fifo #(
    .DEPTH (OUTSTANDING)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push    (accept),
    .push_id (sel_id),
    .pop     (s_data_ok),
    .head_id (head_id),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

endmodule
